// File: rtl/memory_access_stage.sv
// memory_access_stage: SimpleRisc memory-access (MA) stage between execute and writeback.
// Latches the EX bundle, runs ld/st on data memory over a req/ready handshake with a
// MAX_WAIT abort, and drives the registered bundle consumed by writeback.
// Optional build macro MA_ALIGN_CHECK_EN: misaligned ld/st are retired without a
// memory request and flagged on o_misalign_err; when undefined, address bits [1:0]
// are ignored and o_misalign_err is tied low.
// A one-entry hold register keeps the instruction whose access is in flight. When a
// non-memory instruction is accepted on the same edge an access completes, it waits
// in the hold register and retires the cycle after, so writeback sees at most one
// retirement per cycle and program order is kept.
module memory_access_stage #(
    parameter int ADDR_W   = 16,
    parameter int MAX_WAIT = 15
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_ex_valid,
    input  logic [31:0]       i_ex_pc,
    input  logic [31:0]       i_ex_aluresult,
    input  logic [31:0]       i_ex_op2,
    input  logic [31:0]       i_ex_instruction,
    input  logic              i_ex_is_ld,
    input  logic              i_ex_is_st,
    input  logic              i_ex_is_wb,
    input  logic              i_ex_is_call,
    output logic              o_ma_stall,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    input  logic              i_mem_ready,
    input  logic [31:0]       i_mem_rdata,
    output logic              o_rw_valid,
    output logic [31:0]       o_rw_pc,
    output logic [31:0]       o_rw_ldresult,
    output logic [31:0]       o_rw_aluresult,
    output logic [31:0]       o_rw_instruction,
    output logic              o_rw_is_wb,
    output logic              o_rw_is_call,
    output logic              o_rw_is_ld,
    output logic              o_mem_timeout,
    output logic              o_misalign_err
);

    typedef enum logic {S_IDLE, S_ACCESS} state_t;

    localparam logic [7:0] LP_LAST_WAIT = 8'(MAX_WAIT - 1);

    state_t              r_state;
    logic [7:0]          r_waitCnt;
    logic                r_memReq;
    logic                r_memWe;
    logic [ADDR_W-1:0]   r_memAddr;
    logic [31:0]         r_memWdata;

    logic                r_holdValid;
    logic [31:0]         r_holdPc;
    logic [31:0]         r_holdAlu;
    logic [31:0]         r_holdInstr;
    logic                r_holdWb;
    logic                r_holdCall;
    logic                r_holdLd;
    logic                r_holdMis;

    logic                r_rwValid;
    logic [31:0]         r_rwPc;
    logic [31:0]         r_rwLdResult;
    logic [31:0]         r_rwAlu;
    logic [31:0]         r_rwInstr;
    logic                r_rwWb;
    logic                r_rwCall;
    logic                r_rwLd;
    logic                r_timeout;
    logic                r_misalign;

    logic                w_stall;
    logic                w_accept;
    logic                w_isMem;
    logic                w_misaligned;
    logic                w_issue;
    logic                w_loadHold;

    logic                w_retire;
    logic                w_retFromHold;
    logic [31:0]         w_retPc;
    logic [31:0]         w_retLdResult;
    logic [31:0]         w_retAlu;
    logic [31:0]         w_retInstr;
    logic                w_retWb;
    logic                w_retCall;
    logic                w_retLd;
    logic                w_retTimeout;
    logic                w_retMis;

    assign w_stall  = (r_state == S_ACCESS) && !i_mem_ready;
    assign w_accept = i_ex_valid && !w_stall;
    assign w_isMem  = i_ex_is_ld || i_ex_is_st;

`ifdef MA_ALIGN_CHECK_EN
    assign w_misaligned = w_isMem && (i_ex_aluresult[1:0] != 2'b00);
`else
    assign w_misaligned = 1'b0;
`endif

    assign w_issue    = w_accept && w_isMem && !w_misaligned;
    assign w_loadHold = w_accept && (w_issue || w_retFromHold);

    // Decide which instruction, if any, hands its result to writeback at the coming edge
    always_comb begin
        w_retire      = 1'b0;
        w_retFromHold = 1'b0;
        w_retPc       = i_ex_pc;
        w_retLdResult = 32'd0;
        w_retAlu      = i_ex_aluresult;
        w_retInstr    = i_ex_instruction;
        w_retWb       = i_ex_is_wb && !w_misaligned;
        w_retCall     = i_ex_is_call;
        w_retLd       = i_ex_is_ld;
        w_retTimeout  = 1'b0;
        w_retMis      = w_misaligned;
        if (r_state == S_ACCESS) begin
            if (i_mem_ready || (r_waitCnt == LP_LAST_WAIT)) begin
                w_retire      = 1'b1;
                w_retFromHold = 1'b1;
                w_retPc       = r_holdPc;
                w_retAlu      = r_holdAlu;
                w_retInstr    = r_holdInstr;
                w_retCall     = r_holdCall;
                w_retLd       = r_holdLd;
                w_retMis      = 1'b0;
                if (i_mem_ready) begin
                    w_retWb       = r_holdWb;
                    w_retLdResult = r_holdLd ? i_mem_rdata : 32'd0;
                end else begin
                    w_retWb      = 1'b0;
                    w_retTimeout = 1'b1;
                end
            end
        end else if (r_holdValid) begin
            w_retire      = 1'b1;
            w_retFromHold = 1'b1;
            w_retPc       = r_holdPc;
            w_retAlu      = r_holdAlu;
            w_retInstr    = r_holdInstr;
            w_retWb       = r_holdWb;
            w_retCall     = r_holdCall;
            w_retLd       = r_holdLd;
            w_retMis      = r_holdMis;
        end else if (w_accept && !w_issue) begin
            w_retire = 1'b1;
        end
    end

    // Access FSM: issue the request on accept, hold it stable, finish on ready or abort at the wait limit
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_waitCnt  <= 8'd0;
            r_memReq   <= 1'b0;
            r_memWe    <= 1'b0;
            r_memAddr  <= '0;
            r_memWdata <= 32'd0;
        end else if (w_issue) begin
            r_state    <= S_ACCESS;
            r_waitCnt  <= 8'd0;
            r_memReq   <= 1'b1;
            r_memWe    <= i_ex_is_st && !i_ex_is_ld;
            r_memAddr  <= i_ex_aluresult[ADDR_W+1:2];
            r_memWdata <= i_ex_op2;
        end else if (r_state == S_ACCESS) begin
            if (i_mem_ready || (r_waitCnt == LP_LAST_WAIT)) begin
                r_state  <= S_IDLE;
                r_memReq <= 1'b0;
            end else begin
                r_waitCnt <= r_waitCnt + 8'd1;
            end
        end
    end

    // Hold register: the in-flight memory instruction, or a non-memory one waiting its retire slot
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_holdValid <= 1'b0;
            r_holdPc    <= 32'd0;
            r_holdAlu   <= 32'd0;
            r_holdInstr <= 32'd0;
            r_holdWb    <= 1'b0;
            r_holdCall  <= 1'b0;
            r_holdLd    <= 1'b0;
            r_holdMis   <= 1'b0;
        end else begin
            r_holdValid <= w_loadHold && !w_issue;
            if (w_loadHold) begin
                r_holdPc    <= i_ex_pc;
                r_holdAlu   <= i_ex_aluresult;
                r_holdInstr <= i_ex_instruction;
                r_holdWb    <= i_ex_is_wb && !w_misaligned;
                r_holdCall  <= i_ex_is_call;
                r_holdLd    <= i_ex_is_ld;
                r_holdMis   <= w_misaligned;
            end
        end
    end

    // Writeback bundle: load the retiring instruction, otherwise drop valid/is_wb/pulses and hold the data fields
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rwValid    <= 1'b0;
            r_rwPc       <= 32'd0;
            r_rwLdResult <= 32'd0;
            r_rwAlu      <= 32'd0;
            r_rwInstr    <= 32'd0;
            r_rwWb       <= 1'b0;
            r_rwCall     <= 1'b0;
            r_rwLd       <= 1'b0;
            r_timeout    <= 1'b0;
            r_misalign   <= 1'b0;
        end else if (w_retire) begin
            r_rwValid    <= 1'b1;
            r_rwPc       <= w_retPc;
            r_rwLdResult <= w_retLdResult;
            r_rwAlu      <= w_retAlu;
            r_rwInstr    <= w_retInstr;
            r_rwWb       <= w_retWb;
            r_rwCall     <= w_retCall;
            r_rwLd       <= w_retLd;
            r_timeout    <= w_retTimeout;
            r_misalign   <= w_retMis;
        end else begin
            r_rwValid  <= 1'b0;
            r_rwWb     <= 1'b0;
            r_timeout  <= 1'b0;
            r_misalign <= 1'b0;
        end
    end

    assign o_ma_stall       = w_stall;
    assign o_mem_req        = r_memReq;
    assign o_mem_we         = r_memWe;
    assign o_mem_addr       = r_memAddr;
    assign o_mem_wdata      = r_memWdata;
    assign o_rw_valid       = r_rwValid;
    assign o_rw_pc          = r_rwPc;
    assign o_rw_ldresult    = r_rwLdResult;
    assign o_rw_aluresult   = r_rwAlu;
    assign o_rw_instruction = r_rwInstr;
    assign o_rw_is_wb       = r_rwWb;
    assign o_rw_is_call     = r_rwCall;
    assign o_rw_is_ld       = r_rwLd;
    assign o_mem_timeout    = r_timeout;
`ifdef MA_ALIGN_CHECK_EN
    assign o_misalign_err   = r_misalign;
`else
    assign o_misalign_err   = 1'b0;
`endif

endmodule
